// File: rtl/button_event_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | button_event_arbiter_pkg: lane indices, lane FSM encoding, RR helper.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package button_event_arbiter_pkg;

    localparam int LANE_N     = 4;
    localparam int CNT_W      = 19;

    localparam logic [1:0] LANE_LEFT  = 2'd0;
    localparam logic [1:0] LANE_RIGHT = 2'd1;
    localparam logic [1:0] LANE_FIRE  = 2'd2;
    localparam logic [1:0] LANE_START = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLDOFF  = 3'd1,
        WAIT_REL = 3'd2,
        HELD     = 3'd3,
        REPEAT   = 3'd4
    } lane_state_e;

    // First requesting lane at or after ptr, wrapping 3 -> 0. Searching the
    // offsets from largest to smallest lets the nearest one win.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = LANE_N - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_event_arbiter_lane.sv
// +--------------------------------------------------------------------------+
// | button_lane: input synchronizer, press/hold-off/auto-repeat FSM.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module button_lane
    import button_event_arbiter_pkg::*;
#(
    parameter int HOLDOFF_US      = 1000,
    parameter int REPEAT_DELAY_US = 300000,
    parameter int REPEAT_US       = 50000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic tick_i,
    input  logic btn_i,
    output logic event_o
);

    localparam logic [CNT_W-1:0] C_HOLDOFF = CNT_W'(HOLDOFF_US);
    localparam logic [CNT_W-1:0] C_DELAY   = CNT_W'(REPEAT_DELAY_US);
    localparam logic [CNT_W-1:0] C_REPEAT  = CNT_W'(REPEAT_US);

    logic [1:0]       sync_q;
    logic             sync;
    lane_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sync = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Release (sync=0) is tested before any event so it wins in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        event_o = 1'b0;
        if (enable_i) begin
            if (tick_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (sync) begin
                        event_o = 1'b1;
                        state_d = HOLDOFF;
                        cnt_d   = '0;
                    end
                end
                HOLDOFF: begin
                    if (cnt_q >= C_HOLDOFF) begin
                        if (!sync)          state_d = IDLE;
                        else if (REPEAT_EN) state_d = HELD;
                        else                state_d = WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (!sync) state_d = IDLE;
                end
                HELD: begin
                    if (!sync) begin
                        state_d = IDLE;
                    end else if (cnt_q >= C_DELAY) begin
                        event_o = 1'b1;
                        cnt_d   = '0;
                        state_d = REPEAT;
                    end
                end
                REPEAT: begin
                    if (!sync) begin
                        state_d = IDLE;
                    end else if (cnt_q >= C_REPEAT) begin
                        event_o = 1'b1;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/button_event_arbiter.sv
// +--------------------------------------------------------------------------+
// | button_event_arbiter: 4 button lanes arbitrated round-robin into one     |
// | valid/ready command stream. Revision: 1.0                                |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter int         TICK_DIV        = 36,
    parameter int         HOLDOFF_US      = 1000,
    parameter int         REPEAT_DELAY_US = 300000,
    parameter int         REPEAT_US       = 50000,
    parameter logic [3:0] REPEAT_MASK     = 4'b0011
) (
    input  logic       clk_36MHz,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] btn_in,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_code,
    output logic [3:0] pending,
    output logic       overflow
);

    localparam int             PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;
    logic [3:0]       lane_event;
    logic [3:0]       pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [1:0]       cmd_code_q, cmd_code_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             hs;
    logic [3:0]       hs_vec;

    assign tick = enable && (pre_q == C_PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (enable) pre_d = (pre_q == C_PRE_LAST) ? '0 : pre_q + 1'b1;
    end

    for (genvar i = 0; i < LANE_N; i++) begin : g_lanes
        button_lane #(
            .HOLDOFF_US      (HOLDOFF_US),
            .REPEAT_DELAY_US (REPEAT_DELAY_US),
            .REPEAT_US       (REPEAT_US),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_lane (
            .clk_i    (clk_36MHz),
            .rst_i    (reset),
            .enable_i (enable),
            .tick_i   (tick),
            .btn_i    (btn_in[i]),
            .event_o  (lane_event[i])
        );
    end

    // A same-lane handshake frees the slot, so the coincident event is kept.
    always_comb begin
        hs          = cmd_valid_q & cmd_ready;
        hs_vec      = hs ? (4'b0001 << cmd_code_q) : 4'b0000;
        pending_d   = lane_event | (pending_q & ~hs_vec);
        overflow_d  = overflow_q | (|(lane_event & pending_q & ~hs_vec));
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        ptr_d       = ptr_q;
        if (hs) begin
            cmd_valid_d = 1'b0;
            ptr_d       = cmd_code_q + 2'd1;
        end else if (!cmd_valid_q && (pending_q != 4'b0000)) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = rr_pick(pending_q, ptr_q);
        end
    end

    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            pre_q       <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= LANE_LEFT;
            ptr_q       <= LANE_LEFT;
        end else begin
            pre_q       <= pre_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            ptr_q       <= ptr_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_button_event_arbiter: directed self-checking bench, scaled timing.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_button_event_arbiter;

    // Scaled timing: tick = 2 cycles, hold-off 10 us, first repeat 60 us, then every 20 us.
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] btn_in;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_code;
    logic [3:0] pending;
    logic       overflow;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int base;

    logic [1:0] hs_q[$];

    always #5 clk = ~clk;

    button_event_arbiter #(
        .TICK_DIV        (2),
        .HOLDOFF_US      (10),
        .REPEAT_DELAY_US (60),
        .REPEAT_US       (20),
        .REPEAT_MASK     (4'b0011)
    ) dut (
        .clk_36MHz (clk),
        .reset     (reset),
        .enable    (enable),
        .btn_in    (btn_in),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .pending   (pending),
        .overflow  (overflow)
    );

    always @(posedge clk) begin
        if (!reset && cmd_valid && cmd_ready) hs_q.push_back(cmd_code);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        btn_in    = 4'b0000;
        cmd_ready = 1'b1;
        step(3);
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_code", 32'(cmd_code), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        step(5);

        // Single fire press: latency, then bouncing inside the hold-off window.
        base   = hs_q.size();
        btn_in = 4'b0100;
        step();
        chk("t1_e0_valid", 32'(cmd_valid), 32'd0);
        step();
        chk("t1_e1_pending", 32'(pending), 32'd0);
        step();
        chk("t1_e2_pending", 32'(pending), 32'b0100);
        chk("t1_e2_valid", 32'(cmd_valid), 32'd0);
        step();
        chk("t1_e3_valid", 32'(cmd_valid), 32'd1);
        chk("t1_e3_code", 32'(cmd_code), 32'd2);
        step();
        chk("t1_e4_valid", 32'(cmd_valid), 32'd0);
        chk("t1_e4_pending", 32'(pending), 32'd0);
        for (int k = 0; k < 10; k++) begin
            btn_in = {1'b0, k[0], 2'b00};
            step();
        end
        btn_in = 4'b0100;
        step(40);
        btn_in = 4'b0000;
        step(30);
        chk("t1_cmd_count", 32'(hs_q.size() - base), 32'd1);

        // Left held ~90 us: press, repeat at 60 us, repeat at 80 us.
        base   = hs_q.size();
        btn_in = 4'b0001;
        step(100);
        chk("t2_left_early", 32'(hs_q.size() - base), 32'd1);
        step(80);
        btn_in = 4'b0000;
        step(20);
        chk("t2_left_count", 32'(hs_q.size() - base), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (base + k < hs_q.size()) chk("t2_left_code", 32'(hs_q[base + k]), 32'd0);
        end
        step(10);

        // Fire has no auto-repeat.
        base   = hs_q.size();
        btn_in = 4'b0100;
        step(180);
        btn_in = 4'b0000;
        step(30);
        chk("t2_fire_count", 32'(hs_q.size() - base), 32'd1);

        // All four in one cycle from ptr=0: 0,1,2,3 one grant every 2 cycles.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step(2);
        btn_in = 4'b1111;
        step(3);
        chk("t3_pending_all", 32'(pending), 32'hF);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_valid_hi", 32'(cmd_valid), 32'd1);
            chk("t3_code", 32'(cmd_code), 32'(k));
            step();
            chk("t3_valid_lo", 32'(cmd_valid), 32'd0);
        end
        btn_in = 4'b0000;
        step(30);
        btn_in = 4'b0101;
        step(3);
        step();
        chk("t3_wrap_first", 32'(cmd_code), 32'd0);
        step(2);
        chk("t3_wrap_second_valid", 32'(cmd_valid), 32'd1);
        chk("t3_wrap_second", 32'(cmd_code), 32'd2);
        btn_in = 4'b0000;
        step(30);

        // Consumer stalled: second fire press overflows.
        cmd_ready = 1'b0;
        base      = hs_q.size();
        btn_in    = 4'b0100;
        step(4);
        btn_in = 4'b0000;
        step(30);
        chk("t4_first_valid", 32'(cmd_valid), 32'd1);
        chk("t4_first_code", 32'(cmd_code), 32'd2);
        chk("t4_first_overflow", 32'(overflow), 32'd0);
        btn_in = 4'b0100;
        step(4);
        btn_in = 4'b0000;
        step(30);
        chk("t4_pending", 32'(pending), 32'b0100);
        chk("t4_overflow", 32'(overflow), 32'd1);
        cmd_ready = 1'b1;
        step();
        chk("t4_drain_valid", 32'(cmd_valid), 32'd0);
        chk("t4_drain_pending", 32'(pending), 32'd0);
        chk("t4_overflow_sticky", 32'(overflow), 32'd1);
        step(5);
        chk("t4_cmd_count", 32'(hs_q.size() - base), 32'd1);

        // Reset while a command is presented.
        cmd_ready = 1'b0;
        btn_in    = 4'b0100;
        step(4);
        btn_in = 4'b0000;
        step(3);
        chk("t5_pre_valid", 32'(cmd_valid), 32'd1);
        reset = 1'b1;
        step();
        chk("t5_valid", 32'(cmd_valid), 32'd0);
        chk("t5_pending", 32'(pending), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        chk("t5_code", 32'(cmd_code), 32'd0);
        reset     = 1'b0;
        cmd_ready = 1'b1;
        step(30);

        // Enable low freezes the hold count; repeat resumes from where it stopped.
        base   = hs_q.size();
        btn_in = 4'b0001;
        step(60);
        enable = 1'b0;
        step(300);
        chk("t6_frozen", 32'(hs_q.size() - base), 32'd1);
        enable = 1'b1;
        step(40);
        chk("t6_resume_early", 32'(hs_q.size() - base), 32'd1);
        step(40);
        chk("t6_resume_repeat", 32'(hs_q.size() - base), 32'd2);
        btn_in = 4'b0000;
        step(20);
        chk("t6_final", 32'(hs_q.size() - base), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
